fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_stage_if.sv | 25 ++
 rtl/fetch_stage.sv | 74 +++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic {
        REFILL = 1'b0,
        RUN    = 1'b1
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch stage bus: control from execute, instruction memory port, and IF/ID outputs.
interface fetch_stage_if;

    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        misalign_fault;

    modport master (
        input  stall, redirect_valid, redirect_pc, imem_rdata,
        output imem_en, imem_addr, if_valid, if_pc, if_instr, misalign_fault
    );

    modport slave (
        output stall, redirect_valid, redirect_pc, imem_rdata,
        input  imem_en, imem_addr, if_valid, if_pc, if_instr, misalign_fault
    );

endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage against a synchronous (1-cycle read) instruction memory.
// After reset or redirect one REFILL cycle primes the memory before instructions flow.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = fetch_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master bus
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pend_pc_q;
    logic         if_valid_q, misalign_q;
    logic [31:0]  if_pc_q, if_instr_q;
    logic [31:0]  pc_inc;

    assign pc_inc = pc_q + 32'd4;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= REFILL;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.redirect_valid) state_d = REFILL;
        else if (!bus.stall)    state_d = RUN;
    end

    // A stalled RUN re-reads the pending address so its data stays on imem_rdata.
    always_comb begin
        bus.imem_en   = rst_n;
        bus.imem_addr = pc_q;
        if (state_q == RUN && bus.stall && !bus.redirect_valid)
            bus.imem_addr = pend_pc_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            pend_pc_q  <= RESET_PC;
            if_valid_q <= 1'b0;
            if_pc_q    <= 32'h0;
            if_instr_q <= NOP_INSTR;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            if (bus.redirect_valid) begin
                pc_q       <= {bus.redirect_pc[31:2], 2'b00};
                if_valid_q <= 1'b0;
                if_instr_q <= NOP_INSTR;
                misalign_q <= |bus.redirect_pc[1:0];
            end else if (!bus.stall) begin
                pend_pc_q <= pc_q;
                pc_q      <= pc_inc;
                // In REFILL the returned word belongs to a discarded address.
                if (state_q == RUN) begin
                    if_valid_q <= 1'b1;
                    if_pc_q    <= pend_pc_q;
                    if_instr_q <= bus.imem_rdata;
                end
            end
        end
    end

    assign bus.if_valid       = if_valid_q;
    assign bus.if_pc          = if_pc_q;
    assign bus.if_instr       = if_instr_q;
    assign bus.misalign_fault = misalign_q;

endmodule
